// File: rtl/xs3_digit_sequencer.sv
// Streams a BCD word through one shared binary-to-excess-3 converter, one digit
// per clock (LSB first), and presents the collected excess-3 word with a non-BCD flag.
module xs3_digit_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [3:0]          conv_b,
    input  logic [3:0]          conv_e,
    output logic [4*DIGITS-1:0] out_data,
    output logic                out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int            CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_result;
    logic                r_err;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [3:0]          w_digit;

    assign w_digit   = r_shadow[4*r_cnt +: 4];
    // The converter bus is only driven while a digit is actually in flight.
    assign conv_b    = (r_state == CONV) ? w_digit : 4'd0;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_result;
    assign out_err   = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shadow    <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shadow   <= in_data;
                        r_cnt      <= '0;
                        r_err      <= 1'b0;
                        r_result   <= '0;
                        r_state    <= CONV;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                CONV: begin
                    r_result[4*r_cnt +: 4] <= conv_e;
                    r_err                  <= r_err | (w_digit > 4'd9);
                    if (r_cnt == LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xs3_digit_sequencer.sv
// Self-checking bench: per-cycle compare against a timeline model of the
// sequencer plus directed scenarios with literal expectations.
module tb_xs3_digit_sequencer;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*D-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    conv_b;
    logic [3:0]    conv_e;
    logic [4*D-1:0] out_data;
    logic          out_err;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    assign conv_e = conv_b + 4'd3;

    xs3_digit_sequencer #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .conv_b(conv_b), .conv_e(conv_e),
        .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] xs3_word(input logic [4*D-1:0] w);
        logic [4*D-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = w[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic any_non_bcd(input logic [4*D-1:0] w);
        logic e = 1'b0;
        for (int i = 0; i < D; i++) if (w[4*i +: 4] > 4'd9) e = 1'b1;
        return e;
    endfunction

    // Model: a word in flight spends D cycles converting (m_k = 0..D-1),
    // then waits with a valid result until the downstream accepts it.
    logic          m_busy  = 1'b0;
    int            m_k     = 0;
    logic [4*D-1:0] m_word = '0;
    logic          m_fresh = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_fresh <= 1'b1;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_word <= in_data;
            end
        end else if (m_k < D) begin
            m_k <= m_k + 1;
        end else if (out_ready) begin
            m_busy  <= 1'b0;
            m_fresh <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic       ev;
        logic [3:0] eb;
        ev = m_busy && (m_k >= D);
        eb = (m_busy && m_k < D) ? m_word[4*m_k +: 4] : 4'd0;
        chk("m_in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        chk("m_busy", {31'd0, busy}, {31'd0, m_busy});
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("m_conv_b", {28'd0, conv_b}, {28'd0, eb});
        if (ev) begin
            chk("m_out_data", {16'd0, out_data}, {16'd0, xs3_word(m_word)});
            chk("m_out_err", {31'd0, out_err}, {31'd0, any_non_bcd(m_word)});
        end
        if (m_fresh && !m_busy) begin
            chk("m_reset_data", {16'd0, out_data}, 32'd0);
            chk("m_reset_err", {31'd0, out_err}, 32'd0);
        end
    end

    task automatic send(input logic [4*D-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic wait_result(output logic [4*D-1:0] d, output logic e);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("result_timeout", 32'd1, 32'd0);
        d = out_data;
        e = out_err;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*D-1:0] d;
        logic           e;
        logic [3:0]     seq1 [4];
        int             t0, t1;
        seq1 = '{4'h4, 4'h3, 4'h2, 4'h1};

        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_conv_b", {28'd0, conv_b}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 1: digit order and exact latency
        out_ready = 1'b1;
        send(16'h1234);
        for (int i = 0; i < 4; i++) begin
            chk("t1_conv_b", {28'd0, conv_b}, {28'd0, seq1[i]});
            chk("t1_not_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_data", {16'd0, out_data}, 32'h4567);
        chk("t1_err", {31'd0, out_err}, 32'd0);

        // Test 2
        send(16'h9990);
        wait_result(d, e);
        chk("t2_data", {16'd0, d}, 32'hCCC3);
        chk("t2_err", {31'd0, e}, 32'd0);
        chk("t2_in_ready", {31'd0, in_ready}, 32'd0);

        // Test 3: non-BCD wraps and flags, flag clears on next word
        send(16'h00A5);
        wait_result(d, e);
        chk("t3_data", {16'd0, d}, 32'h33D8);
        chk("t3_err", {31'd0, e}, 32'd1);
        send(16'h0000);
        wait_result(d, e);
        chk("t3b_data", {16'd0, d}, 32'h3333);
        chk("t3b_err", {31'd0, e}, 32'd0);

        // Test 4: backpressure
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h1234);
        wait_result(d, e);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_data", {16'd0, out_data}, 32'h4567);
            chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle", {31'd0, in_ready}, 32'd1);
        chk("t4_drop_valid", {31'd0, out_valid}, 32'd0);

        // Test 5: reset during the second conversion cycle
        send(16'h5678);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_no_output", {31'd0, out_valid}, 32'd0);
        end

        // Test 6: back-to-back with in_valid held
        in_data  = 16'h0001;
        in_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        in_data = 16'h0002;
        wait_result(d, e);
        chk("t6_data1", {16'd0, d}, 32'h3334);
        begin
            int n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("t6_timeout", 32'd1, 32'd0);
        end
        t1 = cyc;
        chk("t6_spacing", t1 - t0, 32'd6);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(d, e);
        chk("t6_data2", {16'd0, d}, 32'h3335);
        @(negedge clk);

        // Random traffic, checked by the per-cycle model compare
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_data   = 16'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rst       = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
